demo_master_driver: RTL and testbench
=====================================

// Module: demo_master_driver
// PURPOSE
//  Per-master transaction driver inside demo_top, sitting between the demo controls (start/dN_mode/dN_en)
//  and one bus master's request port; two instances (d1, d2) feed the two bus masters.
//  Converts one active-low start press into exactly one bus read or write to a fixed slave.
//  Walks independent write/read address pointers with a deterministic data pattern; reports dN_ready when idle.
// PARAMETERS
//  ADDR_WIDTH           16     bus address width
//  DATA_WIDTH           8      bus data width
//  SLAVE_MEM_ADDR_WIDTH 12     slave-local address width; upper ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH bits = slave id
//  SLAVE_ID             0      slave id placed in address upper bits
//  DATA_SEED            8'hA5  XOR seed for write-data pattern
//  TIMEOUT              255    max cycles in WAIT before abort (>=1)
// PORTS
//  clk       in   1            clock
//  rstn      in   1            async active-low reset
//  start     in   1            active-low request button/level, asynchronous to clk
//  en        in   1            driver enable (dN_en)
//  mode      in   1            1=write, 0=read (dN_mode)
//  ready     out  1            1 when IDLE (dN_ready)
//  m_valid   out  1            request valid to bus master
//  m_mode    out  1            request mode (1=write)
//  m_addr    out  ADDR_WIDTH   request address
//  m_wdata   out  DATA_WIDTH   request write data
//  m_ready   in   1            bus master can accept request
//  m_done    in   1            one-cycle completion pulse from bus master
//  m_rdata   in   DATA_WIDTH   read data, valid when m_done && read
//  rdata     out  DATA_WIDTH   last completed read data (held)
//  timeout   out  1            sticky: a transaction aborted on TIMEOUT; cleared by next accepted start
//  mismatch  out  1            sticky read-check failure (see CONFIGURATION)
// BEHAVIOUR
//  Reset: ready=1 (state IDLE), m_valid=0, m_mode=0, m_addr=0, m_wdata=0, rdata=0, timeout=0, mismatch=0, wr_ptr=rd_ptr=0.
//  start: 2-flop synchroniser, then falling-edge detect -> start_evt (1 cycle); evt is 3 cycles after start falls.
//  IDLE: on start_evt && en -> latch mode; form addr/data; -> ISSUE; start_evt with en=0 ignored.
//  start_evt outside IDLE is dropped (no queueing); held-low start gives only one event.
//  Write: m_addr={SLAVE_ID, wr_ptr}; m_wdata=wr_ptr[DATA_WIDTH-1:0]^DATA_SEED (zero-extend if ptr narrower).
//  Read: m_addr={SLAVE_ID, rd_ptr}; m_wdata=0.
//  ISSUE: m_valid=1, addr/data/mode stable; accepted in cycle with m_valid&&m_ready -> WAIT, m_valid=0 next cycle.
//  WAIT: cycle counter from 0; m_done -> DONE; counter==TIMEOUT without m_done -> set timeout, -> IDLE, ptr unchanged.
//  m_done in same cycle as timeout expiry counts as completion (done wins).
//  DONE (1 cycle): write -> wr_ptr++; read -> rdata<=m_rdata (captured on m_done), rd_ptr++; -> IDLE.
//  Pointers are SLAVE_MEM_ADDR_WIDTH bits, wrap 4095->0 with no flag.
//  Latency: accept-to-ready = WAIT cycles + 2; ready drops the cycle after start_evt.
//  m_done outside WAIT ignored. rstn low in any state -> immediate reset values, m_valid drops asynchronously.
// CONFIGURATION
//  DEMO_READ_CHECK_EN defined: on read DONE compare m_rdata vs rd_ptr[DATA_WIDTH-1:0]^DATA_SEED;
//   inequality sets mismatch (sticky until reset). Assumes read pointer tracks prior writes.
//  Not defined: no compare logic; mismatch tied 0.
// STRUCTURE
//  demo_pkg: typedef enum logic [1:0] {DRV_IDLE, DRV_ISSUE, DRV_WAIT, DRV_DONE} drv_state_t;
//   localparams MODE_READ=1'b0, MODE_WRITE=1'b1.
//  Sub-module start_sync_edge: 2-flop sync + falling-edge pulse, reset to synced-high (no event on reset release).
// TESTING
//  1 en=1,mode=1, start low 20ns, master m_ready=1, m_done 3 cycles after accept
//    -> m_addr=0x0000, m_wdata=0xA5, one m_valid cycle, ready back high, wr_ptr=1.
//  2 After 1, mode=0 read, m_rdata=0xA5 -> m_addr=0x0000, rdata=0xA5, rd_ptr=1, mismatch=0 (macro on).
//  3 m_ready=0 for 5 cycles during ISSUE -> m_valid held 5+ cycles, addr stable, single accept.
//  4 Never pulse m_done, TIMEOUT=8 -> timeout=1 after 8 WAIT cycles, ready=1, wr_ptr unchanged; next start clears timeout.
//  5 en=0 start press -> no m_valid, ready stays 1; second start during WAIT -> ignored, one transaction only.
//  6 Preload wr_ptr=0xFFF via 4095 writes then write -> m_addr=0x0FFF, ptr wraps to 0; rstn low mid-WAIT -> all reset values.

Source files
------------

// File: rtl/demo_pkg.sv
// Shared types and constants for the demo master driver.
package demo_pkg;

    typedef enum logic [1:0] {DRV_IDLE, DRV_ISSUE, DRV_WAIT, DRV_DONE} drv_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/start_sync_edge.sv
// Two-flop synchroniser for the active-low start input plus a one-cycle falling-edge pulse.
module start_sync_edge (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic start_i,
    output logic evt_o
);

    logic s1_q, s2_q, s3_q;

    // Reset to the released (high) level so reset release never looks like a press.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= start_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign evt_o = s3_q & ~s2_q;

endmodule

// File: rtl/demo_master_driver.sv
// Turns one start press into a single bus read or write with walking address pointers.
// Define DEMO_READ_CHECK_EN to enable the sticky read-data pattern check on mismatch_o.
module demo_master_driver
    import demo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH           = 16,
    parameter int unsigned DATA_WIDTH           = 8,
    parameter int unsigned SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int unsigned SLAVE_ID             = 0,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED  = DATA_WIDTH'(8'hA5),
    parameter int unsigned TIMEOUT              = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    output logic                  ready_o,
    output logic                  m_valid_o,
    output logic                  m_mode_o,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_wdata_o,
    input  logic                  m_ready_i,
    input  logic                  m_done_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  timeout_o,
    output logic                  mismatch_o
);

    localparam int unsigned IdW  = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
    localparam int unsigned PtrW = SLAVE_MEM_ADDR_WIDTH;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IdW-1:0]  SlaveIdBits = IdW'(SLAVE_ID);
    localparam logic [CntW-1:0] CntLast     = CntW'(TIMEOUT - 1);

    function automatic logic [DATA_WIDTH-1:0] data_pattern(input logic [PtrW-1:0] ptr);
        return DATA_WIDTH'(ptr) ^ DATA_SEED;
    endfunction

    drv_state_t            state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  timeout_q, timeout_d;
    logic                  start_evt;

    start_sync_edge u_start_sync_edge (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .evt_o   (start_evt)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        unique case (state_q)
            DRV_IDLE: begin
                if (start_evt && en_i) begin
                    mode_d    = mode_i;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    if (mode_i == MODE_WRITE) begin
                        addr_d  = {SlaveIdBits, wr_ptr_q};
                        wdata_d = data_pattern(wr_ptr_q);
                    end else begin
                        addr_d  = {SlaveIdBits, rd_ptr_q};
                        wdata_d = '0;
                    end
                    state_d = DRV_ISSUE;
                end
            end
            DRV_ISSUE: begin
                if (m_ready_i) begin
                    cnt_d   = '0;
                    state_d = DRV_WAIT;
                end
            end
            DRV_WAIT: begin
                // Completion takes priority over an expiry landing on the same cycle.
                if (m_done_i) begin
                    if (mode_q == MODE_READ) rdata_d = m_rdata_i;
                    state_d = DRV_DONE;
                end else if (cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    state_d   = DRV_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRV_DONE: begin
                if (mode_q == MODE_WRITE) wr_ptr_d = wr_ptr_q + 1'b1;
                else                      rd_ptr_d = rd_ptr_q + 1'b1;
                state_d = DRV_IDLE;
            end
            default: state_d = DRV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= DRV_IDLE;
            mode_q    <= MODE_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DEMO_READ_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == DRV_WAIT && m_done_i && mode_q == MODE_READ &&
            m_rdata_i != data_pattern(rd_ptr_q)) begin
            mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) mismatch_q <= 1'b0;
        else         mismatch_q <= mismatch_d;
    end

    assign mismatch_o = mismatch_q;
`else
    assign mismatch_o = 1'b0;
`endif

    assign ready_o   = (state_q == DRV_IDLE);
    assign m_valid_o = (state_q == DRV_ISSUE);
    assign m_mode_o  = mode_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;
    assign rdata_o   = rdata_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_demo_master_driver.sv
// Directed plus randomized bench for demo_master_driver against a transaction-level model.
module tb_demo_master_driver;

    localparam int TO    = 8;
    localparam int PTR_N = 16;

    logic        clk;
    logic        rstn_i, start_i, en_i, mode_i;
    logic        ready_o, m_valid_o, m_mode_o;
    logic [15:0] m_addr_o;
    logic [7:0]  m_wdata_o;
    logic        m_ready_i, m_done_i;
    logic [7:0]  m_rdata_i;
    logic [7:0]  rdata_o;
    logic        timeout_o, mismatch_o;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the driver should have done so far.
    int         wr_m, rd_m;
    logic [7:0] rdata_m;
    bit         timeout_m, mismatch_m;

    demo_master_driver #(
        .ADDR_WIDTH           (16),
        .DATA_WIDTH           (8),
        .SLAVE_MEM_ADDR_WIDTH (4),
        .SLAVE_ID             (12'h5A3),
        .DATA_SEED            (8'hA5),
        .TIMEOUT              (TO)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .start_i    (start_i),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .ready_o    (ready_o),
        .m_valid_o  (m_valid_o),
        .m_mode_o   (m_mode_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ready_i  (m_ready_i),
        .m_done_i   (m_done_i),
        .m_rdata_i  (m_rdata_i),
        .rdata_o    (rdata_o),
        .timeout_o  (timeout_o),
        .mismatch_o (mismatch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p);
        return 8'(p) ^ 8'hA5;
    endfunction

    function automatic logic [15:0] addr_of(input int p);
        return {12'h5A3, 4'(p)};
    endfunction

    task automatic model_reset();
        wr_m = 0; rd_m = 0; rdata_m = 8'h00; timeout_m = 0; mismatch_m = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdata"}, rdata_o, rdata_m);
        check({tag, "_timeout"}, timeout_o, timeout_m);
        check({tag, "_mismatch"}, mismatch_o, mismatch_m);
    endtask

    // One press; bus accepts after rdly cycles, pulses m_done at WAIT cycle ddly (0-based).
    task automatic txn(input bit mode, input bit en, input int rdly, input int ddly,
                       input logic [7:0] rv, input bit extra_press);
        int n;
        bit bad;
        logic [15:0] exp_addr;
        @(negedge clk);
        mode_i = mode; en_i = en; start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start_i = 1'b1;
        if (!en) begin
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (m_valid_o || !ready_o) bad = 1;
            end
            check("en0_ignored", bad, 0);
            return;
        end
        n = 0;
        while (!m_valid_o && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", m_valid_o, 1);
        if (!m_valid_o) return;
        timeout_m = 0;
        exp_addr  = addr_of(mode ? wr_m : rd_m);
        check("issue_addr", m_addr_o, exp_addr);
        check("issue_wdata", m_wdata_o, mode ? pat(wr_m) : 8'h00);
        check("issue_mode", m_mode_o, mode);
        check("issue_ready", ready_o, 0);
        check("issue_timeout_clr", timeout_o, 0);
        bad = 0;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            if (m_valid_o !== 1'b1 || m_addr_o !== exp_addr) bad = 1;
        end
        if (rdly > 0) check("issue_hold", bad, 0);
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        check("valid_drop", m_valid_o, 0);
        for (int k = 0; k <= ddly && k < TO + 2; k++) begin
            m_done_i  = (k == ddly);
            m_rdata_i = rv;
            if (extra_press) start_i = !(k == 0 || k == 1);
            @(negedge clk);
        end
        m_done_i = 1'b0;
        start_i  = 1'b1;
        n = 0;
        while (!ready_o && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("ready_back", ready_o, 1);
        if (ddly < TO) begin
            if (mode) begin
                wr_m = (wr_m + 1) % PTR_N;
            end else begin
                rdata_m = rv;
`ifdef DEMO_READ_CHECK_EN
                if (rv != pat(rd_m)) mismatch_m = 1;
`endif
                rd_m = (rd_m + 1) % PTR_N;
            end
        end else begin
            timeout_m = 1;
        end
        check_idle_outputs("post");
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid_o) bad = 1;
        end
        check("single_txn", bad, 0);
    endtask

    initial begin
        bit          md, en, xp;
        int          rdly, ddly;
        logic [7:0]  rv;
        rstn_i = 1'b0; start_i = 1'b1; en_i = 1'b1; mode_i = 1'b0;
        m_ready_i = 1'b0; m_done_i = 1'b0; m_rdata_i = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_valid", m_valid_o, 0);
        check("rst_mode", m_mode_o, 0);
        check("rst_addr", m_addr_o, 0);
        check("rst_wdata", m_wdata_o, 0);
        check_idle_outputs("rst");
        rstn_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release_no_evt", m_valid_o, 0);

        txn(1, 1, 0, 3, 8'h00, 0);            // first write: addr ptr 0, data A5
        txn(0, 1, 0, 3, 8'hA5, 0);            // first read returns matching pattern
        txn(1, 1, 5, 2, 8'h00, 0);            // stalled accept
        txn(1, 1, 0, 100, 8'h00, 0);          // no completion: timeout
        txn(1, 1, 0, 1, 8'h00, 0);            // next press clears timeout
        txn(0, 1, 1, TO - 1, pat(rd_m), 0);   // done on the expiry cycle wins
        txn(0, 1, 0, TO, 8'h3C, 0);           // done one cycle late is ignored
        txn(1, 0, 0, 0, 8'h00, 0);            // disabled press
        txn(1, 1, 0, 6, 8'h00, 1);            // second press during WAIT dropped
        txn(0, 1, 0, 2, 8'h5A, 0);            // wrong read data

        while (wr_m != PTR_N - 1) txn(1, 1, 0, 0, 8'h00, 0);
        txn(1, 1, 0, 0, 8'h00, 0);            // write at last pointer
        txn(1, 1, 0, 0, 8'h00, 0);            // wrapped back to 0

        for (int it = 0; it < 30; it++) begin
            md   = 1'($urandom % 2);
            en   = ($urandom % 6) != 0;
            rdly = $urandom % 4;
            ddly = (($urandom % 8) == 0) ? TO : int'($urandom % TO);
            rv   = (($urandom % 4) == 0) ? 8'($urandom) : pat(rd_m);
            xp   = (ddly >= 3 && ddly < TO) ? 1'($urandom % 2) : 1'b0;
            txn(md, en, rdly, ddly, rv, xp);
        end

        // Reset in the middle of WAIT.
        @(negedge clk);
        mode_i = 1'b1; en_i = 1'b1; start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_valid_pre", m_valid_o, 1);
        m_ready_i = 1'b1;
        @(negedge clk);
        m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rstn_i = 1'b0;
        #1;
        model_reset();
        check("midrst_ready", ready_o, 1);
        check("midrst_valid", m_valid_o, 0);
        check("midrst_addr", m_addr_o, 0);
        check("midrst_wdata", m_wdata_o, 0);
        check("midrst_mode", m_mode_o, 0);
        check_idle_outputs("midrst");
        @(negedge clk);
        rstn_i = 1'b1;
        txn(1, 1, 0, 1, 8'h00, 0);
        txn(0, 1, 0, 1, 8'hA5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
